// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs,
// FSM states and the datapath select/ALU codes.
package mc_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25,
                         F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLLV = 6'h04;

  typedef enum logic [3:0] {
    S_INIT, S_IF, S_ID, S_EX_R, S_EX_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_R, S_WB_I, S_WB_LW, S_BR, S_JMP
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLLV = 4'd7,
                         ALU_LUI = 4'd8;

  localparam logic [2:0] SRCB_B = 3'b000, SRCB_FOUR = 3'b001, SRCB_SEXT = 3'b010,
                         SRCB_ZEXT = 3'b011, SRCB_SEXT_SH2 = 3'b100;

  localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10;
  localparam logic [1:0] WDS_ALU = 2'b00, WDS_MDR = 2'b01, WDS_PC = 2'b10;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI,
      OP_XORI, OP_LUI, OP_LW, OP_SW: op_legal = 1'b1;
      default:                       op_legal = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/mc_control_fsm_alu_op_decode.sv
// ALU operation select from (state, opcode, funct); flags unknown R-type functs.
module alu_op_decode
  import mc_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic [3:0]  alu_op,
  output logic        bad_funct
);
  always_comb begin
    alu_op    = ALU_ADD;
    bad_funct = 1'b0;
    case (state)
      S_EX_R:
        case (funct)
          F_ADD:   alu_op = ALU_ADD;
          F_SUB:   alu_op = ALU_SUB;
          F_AND:   alu_op = ALU_AND;
          F_OR:    alu_op = ALU_OR;
          F_XOR:   alu_op = ALU_XOR;
          F_NOR:   alu_op = ALU_NOR;
          F_SLT:   alu_op = ALU_SLT;
          F_SLLV:  alu_op = ALU_SLLV;
          default: bad_funct = 1'b1;
        endcase
      S_EX_I:
        case (opcode)
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          OP_XORI: alu_op = ALU_XOR;
          OP_LUI:  alu_op = ALU_LUI;
          default: alu_op = ALU_ADD;
        endcase
      S_BR:    alu_op = ALU_SUB;
      default: alu_op = ALU_ADD;
    endcase
  end
endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: state register plus Moore decode of
// state and the latched instruction word into datapath controls.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter logic [4:0] WB_JAL_REG = 5'd31
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic [31:0] Inst,
  input  logic        Zero,
  output logic [4:0]  R_Addr_A,
  output logic [4:0]  R_Addr_B,
  output logic [4:0]  W_Addr,
  output logic        Write_Reg,
  output logic        PC_Write,
  output logic        IR_Write,
  output logic        Mem_Write,
  output logic [1:0]  PC_Src,
  output logic        ALU_SrcA,
  output logic [2:0]  ALU_SrcB,
  output logic [3:0]  ALU_OP,
  output logic [1:0]  W_Data_Src,
  output logic        Illegal
);
  state_t     state;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic       bad_funct, wr_en;
  logic       unused_shamt;

  assign opcode       = Inst[31:26];
  assign funct        = Inst[5:0];
  assign rs           = Inst[25:21];
  assign rt           = Inst[20:16];
  assign rd           = Inst[15:11];
  assign unused_shamt = ^Inst[10:6];

  alu_op_decode u_alu_dec (
    .state     (state),
    .opcode    (opcode),
    .funct     (funct),
    .alu_op    (ALU_OP),
    .bad_funct (bad_funct)
  );

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_INIT;
    else begin
      case (state)
        S_INIT: state <= S_IF;
        S_IF:   state <= S_ID;
        S_ID:
          case (opcode)
            OP_RTYPE:                                state <= S_EX_R;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state <= S_EX_I;
            OP_LW, OP_SW:                            state <= S_MEM_ADDR;
            OP_BEQ, OP_BNE:                          state <= S_BR;
            OP_J, OP_JAL:                            state <= S_JMP;
            default:                                 state <= S_IF;
          endcase
        S_EX_R:     state <= bad_funct ? S_IF : S_WB_R;
        S_EX_I:     state <= S_WB_I;
        S_MEM_ADDR: state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   state <= S_WB_LW;
        default:    state <= S_IF;
      endcase
    end
  end

  // Outputs are combinational off the state register, so the async reset
  // (state -> INIT) drops every strobe immediately.
  always_comb begin
    R_Addr_A   = (state == S_INIT) ? 5'd0 : rs;
    R_Addr_B   = (state == S_INIT) ? 5'd0 : rt;
    W_Addr     = 5'd0;
    wr_en      = 1'b0;
    PC_Write   = 1'b0;
    IR_Write   = 1'b0;
    Mem_Write  = 1'b0;
    PC_Src     = PCS_ALU;
    ALU_SrcA   = 1'b0;
    ALU_SrcB   = SRCB_B;
    W_Data_Src = WDS_ALU;
    Illegal    = 1'b0;
    case (state)
      S_IF: begin
        PC_Write = 1'b1;
        IR_Write = 1'b1;
        ALU_SrcB = SRCB_FOUR;
      end
      S_ID: begin
        ALU_SrcB = SRCB_SEXT_SH2;
        Illegal  = !op_legal(opcode);
      end
      S_EX_R: begin
        ALU_SrcA = 1'b1;
        Illegal  = bad_funct;
      end
      S_EX_I: begin
        ALU_SrcA = 1'b1;
        ALU_SrcB = (opcode == OP_ADDI) ? SRCB_SEXT : SRCB_ZEXT;
      end
      S_MEM_ADDR: begin
        ALU_SrcA = 1'b1;
        ALU_SrcB = SRCB_SEXT;
      end
      S_MEM_WR: Mem_Write = 1'b1;
      S_WB_R: begin
        W_Addr = rd;
        wr_en  = 1'b1;
      end
      S_WB_I: begin
        W_Addr = rt;
        wr_en  = 1'b1;
      end
      S_WB_LW: begin
        W_Addr     = rt;
        wr_en      = 1'b1;
        W_Data_Src = WDS_MDR;
      end
      S_BR: begin
        ALU_SrcA = 1'b1;
        PC_Src   = PCS_ALUOUT;
        PC_Write = (opcode == OP_BNE) ? ~Zero : Zero;
      end
      S_JMP: begin
        PC_Write = 1'b1;
        PC_Src   = PCS_JUMP;
        if (opcode == OP_JAL) begin
          W_Addr     = WB_JAL_REG;
          wr_en      = 1'b1;
          W_Data_Src = WDS_PC;
        end
      end
      default: ;
    endcase
    Write_Reg = wr_en && (W_Addr != 5'd0);
  end
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed-vector bench for mc_control_fsm; expected output words are hand-built.
module tb_mc_control_fsm;
  logic        clk = 1'b0;
  logic        Reset_n;
  logic [31:0] Inst;
  logic        Zero;
  logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
  logic        Write_Reg, PC_Write, IR_Write, Mem_Write, ALU_SrcA, Illegal;
  logic [1:0]  PC_Src, W_Data_Src;
  logic [2:0]  ALU_SrcB;
  logic [3:0]  ALU_OP;
  int          nvec = 0, nerr = 0;

  mc_control_fsm #(.WB_JAL_REG(5'd31)) dut (
    .clk(clk), .Reset_n(Reset_n), .Inst(Inst), .Zero(Zero),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr), .Write_Reg(Write_Reg),
    .PC_Write(PC_Write), .IR_Write(IR_Write), .Mem_Write(Mem_Write), .PC_Src(PC_Src),
    .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB), .ALU_OP(ALU_OP),
    .W_Data_Src(W_Data_Src), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  // {pcw, irw, memw, pcsrc, srca, srcb, aluop, wds, waddr, wreg, illegal}
  logic [21:0] act;
  assign act = {PC_Write, IR_Write, Mem_Write, PC_Src, ALU_SrcA, ALU_SrcB, ALU_OP,
                W_Data_Src, W_Addr, Write_Reg, Illegal};

  function automatic logic [21:0] pk(input logic pcw, irw, mw, input logic [1:0] pcs,
                                     input logic sa, input logic [2:0] sb,
                                     input logic [3:0] op, input logic [1:0] wds,
                                     input logic [4:0] wa, input logic wr, il);
    return {pcw, irw, mw, pcs, sa, sb, op, wds, wa, wr, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cyc(input string tag, input logic [21:0] exp);
    step();
    chk(tag, {10'd0, act}, {10'd0, exp});
  endtask

  task automatic fetch(input string tag, input logic [31:0] inst);
    step();
    Inst = inst;
    chk(tag, {10'd0, act}, {10'd0, pk(1,1,0,2'b00,0,3'b001,4'd0,2'b00,5'd0,0,0)});
  endtask

  logic [21:0] IDV;

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    IDV = pk(0,0,0,2'b00,0,3'b100,4'd0,2'b00,5'd0,0,0);
    Reset_n = 1'b0; Inst = 32'h0; Zero = 1'b0;
    repeat (3) begin
      step();
      chk("rst_out", {10'd0, act}, 32'd0);
      chk("rst_addr", {22'd0, R_Addr_A, R_Addr_B}, 32'd0);
    end
    Reset_n = 1'b1;
    Inst = 32'h00221820;
    chk("init_out", {10'd0, act}, 32'd0);
    chk("init_addr", {22'd0, R_Addr_A, R_Addr_B}, 32'd0);

    // add $3,$1,$2
    fetch("add_if", 32'h00221820);
    chk("add_raddr", {22'd0, R_Addr_A, R_Addr_B}, {22'd0, 5'd1, 5'd2});
    cyc("add_id", IDV);
    cyc("add_ex", pk(0,0,0,2'b00,1,3'b000,4'd0,2'b00,5'd0,0,0));
    cyc("add_wb", pk(0,0,0,2'b00,0,3'b000,4'd0,2'b00,5'd3,1,0));

    // lw $5,8($4)
    fetch("lw_if", 32'h8C850008);
    cyc("lw_id", IDV);
    chk("lw_raddr", {22'd0, R_Addr_A, R_Addr_B}, {22'd0, 5'd4, 5'd5});
    cyc("lw_addr", pk(0,0,0,2'b00,1,3'b010,4'd0,2'b00,5'd0,0,0));
    cyc("lw_rd", 22'd0);
    cyc("lw_wb", pk(0,0,0,2'b00,0,3'b000,4'd0,2'b01,5'd5,1,0));

    // beq taken, then not taken
    fetch("beq_if", 32'h1022FFFF);
    cyc("beq_id", IDV);
    Zero = 1'b1;
    cyc("beq_tk", pk(1,0,0,2'b01,1,3'b000,4'd1,2'b00,5'd0,0,0));
    Zero = 1'b0;
    fetch("beq2_if", 32'h1022FFFF);
    cyc("beq2_id", IDV);
    cyc("beq_nt", pk(0,0,0,2'b01,1,3'b000,4'd1,2'b00,5'd0,0,0));

    // addi $0,$1,5 must not write r0
    fetch("addi_if", 32'h20200005);
    cyc("addi_id", IDV);
    cyc("addi_ex", pk(0,0,0,2'b00,1,3'b010,4'd0,2'b00,5'd0,0,0));
    cyc("addi_wb", 22'd0);

    // jal
    fetch("jal_if", 32'h0C000010);
    cyc("jal_id", IDV);
    cyc("jal_jmp", pk(1,0,0,2'b10,0,3'b000,4'd0,2'b10,5'd31,1,0));

    // ori $6,$1,0xFF
    fetch("ori_if", 32'h342600FF);
    cyc("ori_id", IDV);
    cyc("ori_ex", pk(0,0,0,2'b00,1,3'b011,4'd3,2'b00,5'd0,0,0));
    cyc("ori_wb", pk(0,0,0,2'b00,0,3'b000,4'd0,2'b00,5'd6,1,0));

    // R-type with unknown funct
    fetch("badf_if", 32'h0022183F);
    cyc("badf_id", IDV);
    cyc("badf_ex", pk(0,0,0,2'b00,1,3'b000,4'd0,2'b00,5'd0,0,1));

    // illegal opcode 0x3F
    fetch("badop_if", 32'hFC000000);
    cyc("badop_id", pk(0,0,0,2'b00,0,3'b100,4'd0,2'b00,5'd0,0,1));

    // sw, aborted by reset in MEM_WR
    fetch("sw_if", 32'hAC850008);
    cyc("sw_id", IDV);
    cyc("sw_addr", pk(0,0,0,2'b00,1,3'b010,4'd0,2'b00,5'd0,0,0));
    cyc("sw_wr", pk(0,0,1,2'b00,0,3'b000,4'd0,2'b00,5'd0,0,0));
    #2 Reset_n = 1'b0;
    #1 chk("abort_memw", {31'd0, Mem_Write}, 32'd0);
    chk("abort_out", {10'd0, act}, 32'd0);
    step();
    chk("rst2_out", {10'd0, act}, 32'd0);
    Reset_n = 1'b1;
    chk("init2_out", {10'd0, act}, 32'd0);
    fetch("restart_if", 32'h00221820);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
